// File: rtl/add_seq_ctrl.sv
// Sequential W-bit adder/subtractor that walks the operands one byte per cycle
// through a single shared external 8-bit carry-lookahead adder slice.
module add_seq_ctrl #(
  parameter int NUM_BYTES = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     sub,
  input  logic [8*NUM_BYTES-1:0]   operand_a,
  input  logic [8*NUM_BYTES-1:0]   operand_b,
  output logic                     busy,
  output logic                     done,
  output logic [8*NUM_BYTES-1:0]   result,
  output logic                     cout,
  output logic                     overflow,
  output logic [7:0]               blk_x,
  output logic [7:0]               blk_y,
  output logic                     blk_c0,
  input  logic [7:0]               blk_s,
  input  logic                     blk_c8
);

  localparam int W    = 8 * NUM_BYTES;
  localparam int IDXW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic            in_run;
  logic            accept;
  logic [7:0]      a_byte;
  logic [7:0]      b_byte;

  assign in_run = (state_q == S_RUN);
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign a_byte = a_q[{idx_q, 3'b000} +: 8];
  assign b_byte = b_q[{idx_q, 3'b000} +: 8];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // B is stored already inverted for subtraction; carry-in of 1 completes A + ~B + 1
        if (accept) begin
          a_d     = operand_a;
          b_d     = sub ? ~operand_b : operand_b;
          carry_d = sub;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        result_d[{idx_q, 3'b000} +: 8] = blk_s;
        carry_d = blk_c8;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = blk_c8;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (blk_s[7] != a_q[W-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = in_run;
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign blk_x    = in_run ? a_byte  : 8'h00;
  assign blk_y    = in_run ? b_byte  : 8'h00;
  assign blk_c0   = in_run ? carry_q : 1'b0;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed self-checking bench for add_seq_ctrl (NUM_BYTES=4) with a behavioral
// 8-bit adder standing in for the external slice.
module tb_add_seq_ctrl;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        sub;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        overflow;
  logic [7:0]  blk_x;
  logic [7:0]  blk_y;
  logic        blk_c0;
  logic [7:0]  blk_s;
  logic        blk_c8;

  int checkCount = 0;
  int errorCount = 0;

  add_seq_ctrl #(.NUM_BYTES(4)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .sub      (sub),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .blk_x    (blk_x),
    .blk_y    (blk_y),
    .blk_c0   (blk_c0),
    .blk_s    (blk_s),
    .blk_c8   (blk_c8)
  );

  assign {blk_c8, blk_s} = {1'b0, blk_x} + {1'b0, blk_y} + {8'b0, blk_c0};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one operation, scrambles the inputs after acceptance, and follows it to done
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic [31:0] expRes,
                               input logic expCout, input logic expOvf);
    logic [31:0] bEff;
    logic        prevC8;
    int          busyCnt;
    int          doneAt;
    bEff    = s ? ~b : b;
    prevC8  = 1'b0;
    busyCnt = 0;
    doneAt  = 0;
    @(negedge clock);
    start = 1'b1; sub = s; operand_a = a; operand_b = b;
    @(posedge clock);
    #1;
    start = 1'b0; sub = ~s; operand_a = ~a; operand_b = ~b;
    for (int cyc = 1; cyc <= 10 && doneAt == 0; cyc++) begin
      @(negedge clock);
      if (busy) begin
        checkOutput({tag, ".blkX"}, blk_x, 8'(a >> (8 * busyCnt)));
        checkOutput({tag, ".blkY"}, blk_y, 8'(bEff >> (8 * busyCnt)));
        checkOutput({tag, ".blkC0"}, blk_c0, (busyCnt == 0) ? s : prevC8);
        prevC8 = blk_c8;
        busyCnt++;
      end
      if (done) doneAt = cyc;
    end
    checkOutput({tag, ".doneCycle"}, doneAt, 5);
    checkOutput({tag, ".busyCycles"}, busyCnt, 4);
    checkOutput({tag, ".result"}, result, expRes);
    checkOutput({tag, ".cout"}, cout, expCout);
    checkOutput({tag, ".overflow"}, overflow, expOvf);
    @(negedge clock);
    checkOutput({tag, ".donePulse"}, done, 0);
    checkOutput({tag, ".resultHeld"}, result, expRes);
    checkOutput({tag, ".idleBlkX"}, blk_x, 0);
  endtask

  always @(negedge clock) begin
    if (reset_n && busy && done) checkOutput("busyDoneExclusive", {busy, done}, 2'b10);
  end

  logic [31:0] bbA [3] = '{32'h0000_0001, 32'h1234_5678, 32'h8000_0000};
  logic [31:0] bbB [3] = '{32'h0000_0002, 32'h1111_1111, 32'h0000_0001};
  logic        bbS [3] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] bbR [3] = '{32'h0000_0003, 32'h2345_6789, 32'h7FFF_FFFF};
  logic        bbC [3] = '{1'b0, 1'b0, 1'b1};
  logic        bbO [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    int  k;
    int  lastDone;
    logic sawDone;
    reset_n = 1'b0; start = 1'b0; sub = 1'b0; operand_a = '0; operand_b = '0;
    #1;
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.done", done, 0);
    checkOutput("rst.result", result, 0);
    checkOutput("rst.blkC0", blk_c0, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    applyStimulus("addCarry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    applyStimulus("addOvf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    applyStimulus("subNeg",   32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    applyStimulus("subPos",   32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    applyStimulus("addWrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus("addNegOv", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    // Back-to-back: start stays high, new operands presented in each DONE cycle
    @(negedge clock);
    start = 1'b1; sub = bbS[0]; operand_a = bbA[0]; operand_b = bbB[0];
    k = 0;
    lastDone = 0;
    for (int cyc = 1; cyc <= 40 && k < 3; cyc++) begin
      @(negedge clock);
      if (done) begin
        checkOutput($sformatf("b2b%0d.result", k), result, bbR[k]);
        checkOutput($sformatf("b2b%0d.cout", k), cout, bbC[k]);
        checkOutput($sformatf("b2b%0d.overflow", k), overflow, bbO[k]);
        checkOutput($sformatf("b2b%0d.gap", k), cyc - lastDone, 5);
        lastDone = cyc;
        k++;
        if (k < 3) begin
          sub = bbS[k]; operand_a = bbA[k]; operand_b = bbB[k];
        end else begin
          start = 1'b0;
        end
      end else begin
        operand_a = 32'(cyc) * 32'h0101_0101;
        operand_b = ~operand_a;
        sub = ~sub;
      end
    end
    checkOutput("b2b.count", k, 3);
    start = 1'b0;

    // Abort in the second RUN cycle; the first byte has already been written
    @(negedge clock);
    start = 1'b1; sub = 1'b0; operand_a = 32'hFFFF_FFFF; operand_b = 32'h0000_0001;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #2;
    checkOutput("abort.partial", result, 32'h7FFF_FF00);
    checkOutput("abort.busyBefore", busy, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort.busy", busy, 0);
    checkOutput("abort.done", done, 0);
    checkOutput("abort.result", result, 0);
    checkOutput("abort.cout", cout, 0);
    checkOutput("abort.overflow", overflow, 0);
    checkOutput("abort.blk", {blk_x, blk_y, blk_c0}, 0);
    sawDone = 1'b0;
    repeat (3) begin
      @(negedge clock);
      sawDone = sawDone | done;
    end
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      sawDone = sawDone | done;
    end
    checkOutput("abort.noDone", sawDone, 0);
    applyStimulus("afterRst", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
